// File: rtl/interp_seq_pkg.sv
// Shared constants and y_bus slicing for the 10x interpolator sequencer.
package interp_seq_pkg;
  localparam int PHASES   = 10;
  localparam int SAMPLE_W = 8;
  localparam int PHASE_W  = 4;

  typedef logic [SAMPLE_W-1:0] sample_t;

  function automatic sample_t y_slice(input logic [PHASES*SAMPLE_W-1:0] y, input int k);
    return y[k*SAMPLE_W +: SAMPLE_W];
  endfunction
endpackage

// File: rtl/interp_strobe_gen.sv
// Slot/frame strobe generator: div_cnt, phase counter and registered strobes.
module interp_strobe_gen
  import interp_seq_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  output logic               slot,
  output logic [PHASE_W-1:0] phase,
  output logic               clk_en,
  output logic               clk_en_10x
);
  localparam int DW = 8;

  logic [DW-1:0]      div_cnt_q, div_cnt_d;
  logic [PHASE_W-1:0] p_q, p_d;
  logic               clk_en_q, clk_en_d, clk_en_10x_q, clk_en_10x_d;

  always_comb begin
    slot         = enable && (div_cnt_q == DW'(DIV - 1));
    div_cnt_d    = div_cnt_q;
    p_d          = p_q;
    if (!enable) begin
      div_cnt_d = '0;
      p_d       = '0;
    end else if (slot) begin
      div_cnt_d = '0;
      p_d       = (p_q == PHASE_W'(PHASES - 1)) ? '0 : p_q + 1'b1;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
    // strobes are registered, so they trail the internal slot by one cycle
    clk_en_10x_d = slot;
    clk_en_d     = slot && (p_q == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q    <= '0;
      p_q          <= '0;
      clk_en_q     <= 1'b0;
      clk_en_10x_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      p_q          <= p_d;
      clk_en_q     <= clk_en_d;
      clk_en_10x_q <= clk_en_10x_d;
    end
  end

  assign phase      = p_q;
  assign clk_en     = clk_en_q;
  assign clk_en_10x = clk_en_10x_q;
endmodule

// File: rtl/interp_10x_sequencer.sv
// Sequencer for the 10x interpolator: input holding, pair load, capture, serializer.
// Optional saturating underrun counter under INTERP_SEQ_UNDERRUN_CNT_EN.
module interp_10x_sequencer
  import interp_seq_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic        clk_en,
  output logic        clk_en_10x,
  output logic [7:0]  x0,
  output logic [7:0]  x1,
  input  logic        end_stage,
  input  logic [79:0] y_bus,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        underrun,
  input  logic        underrun_clr,
  output logic [7:0]  underrun_cnt
);
  logic               slot;
  logic [PHASE_W-1:0] phase;
  logic               ld, acc, ur;

  // capture happens on schedule regardless of end_stage
  logic unused_end_stage;
  assign unused_end_stage = end_stage;

  interp_strobe_gen #(.DIV(DIV)) u_strobe (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .slot       (slot),
    .phase      (phase),
    .clk_en     (clk_en),
    .clk_en_10x (clk_en_10x)
  );

  sample_t                          hold_q, hold_d, x0_q, x0_d, x1_q, x1_d, m_data_q, m_data_d;
  logic [PHASES-1:0][SAMPLE_W-1:0]  obuf_q, obuf_d;
  logic                             hold_full_q, hold_full_d, s_ready_q, s_ready_d;
  logic                             obuf_valid_q, obuf_valid_d, m_valid_q, m_valid_d;
  logic                             underrun_q, underrun_d;
  logic [1:0]                       loads_q, loads_d;

  always_comb begin
    ld           = slot && (phase == PHASE_W'(PHASES - 1));
    acc          = s_valid && s_ready_q;
    ur           = ld && !hold_full_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    x0_d         = x0_q;
    x1_d         = x1_q;
    obuf_d       = obuf_q;
    obuf_valid_d = obuf_valid_q;
    loads_d      = loads_q;
    m_data_d     = m_data_q;
    underrun_d   = underrun_q;
    if (ld) begin
      for (int k = 0; k < PHASES; k++) obuf_d[k] = y_slice(y_bus, k);
      // the first two loads only prime x0/x1, so their captures are discarded
      obuf_valid_d = obuf_valid_q | loads_q[1];
      if (loads_q != 2'd3) loads_d = loads_q + 1'b1;
      x0_d = x1_q;
      if (hold_full_q) begin
        x1_d        = hold_q;
        hold_full_d = 1'b0;
      end
    end
    if (acc) begin
      hold_d      = s_data;
      hold_full_d = 1'b1;
    end
    s_ready_d = !hold_full_d;
    m_valid_d = slot && obuf_valid_q;
    if (slot) m_data_d = obuf_q[phase];
    if (underrun_clr) underrun_d = 1'b0;
    if (ur)           underrun_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      s_ready_q    <= 1'b0;
      x0_q         <= '0;
      x1_q         <= '0;
      obuf_q       <= '0;
      obuf_valid_q <= 1'b0;
      loads_q      <= '0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      s_ready_q    <= s_ready_d;
      x0_q         <= x0_d;
      x1_q         <= x1_d;
      obuf_q       <= obuf_d;
      obuf_valid_q <= obuf_valid_d;
      loads_q      <= loads_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      underrun_q   <= underrun_d;
    end
  end

`ifdef INTERP_SEQ_UNDERRUN_CNT_EN
  logic [7:0] ucnt_q, ucnt_d;
  always_comb begin
    ucnt_d = ucnt_q;
    if (underrun_clr)             ucnt_d = {7'd0, ur};
    else if (ur && ucnt_q != 8'hFF) ucnt_d = ucnt_q + 8'd1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ucnt_q <= '0;
    else       ucnt_q <= ucnt_d;
  end
  assign underrun_cnt = ucnt_q;
`else
  assign underrun_cnt = 8'h00;
`endif

  assign s_ready  = s_ready_q;
  assign x0       = x0_q;
  assign x1       = x1_q;
  assign m_data   = m_data_q;
  assign m_valid  = m_valid_q;
  assign underrun = underrun_q;
endmodule

// File: tb/tb_interp_10x_sequencer.sv
// Self-checking bench for interp_10x_sequencer with a frame-level reference model.
module tb_interp_10x_sequencer;
  localparam int DIV = 2;

  logic        clk, reset, enable, s_valid, s_ready, clk_en, clk_en_10x;
  logic        end_stage, m_valid, underrun, underrun_clr;
  logic [7:0]  s_data, x0, x1, m_data, underrun_cnt;
  logic [79:0] y_bus;

  int pass_cnt = 0, tot_cnt = 0;

  interp_10x_sequencer #(.DIV(DIV)) dut (
    .clk(clk), .reset(reset), .enable(enable), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .clk_en(clk_en), .clk_en_10x(clk_en_10x), .x0(x0), .x1(x1),
    .end_stage(end_stage), .y_bus(y_bus), .m_data(m_data), .m_valid(m_valid),
    .underrun(underrun), .underrun_clr(underrun_clr), .underrun_cnt(underrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // interpolator stub: y[k] = x0 + k
  always_comb for (int k = 0; k < 10; k++) y_bus[8*k +: 8] = x0 + 8'(k);

  // reference model state
  int         ecyc, scnt, loads;
  bit         ovalid, erdy, ece, ece10, emv, eur;
  logic [7:0] hq[$];
  logic [7:0] ex0, ex1, emd;
  logic [7:0] eob[10];
  int         ecnt;

  task automatic model_reset();
    ecyc = 0; scnt = 0; loads = 0; ovalid = 0; hq.delete();
    ex0 = 0; ex1 = 0; emd = 0; erdy = 0; ece = 0; ece10 = 0; emv = 0; eur = 0; ecnt = 0;
    for (int k = 0; k < 10; k++) eob[k] = 8'h00;
  endtask

  function automatic bit will_load();
    return enable && ((ecyc % DIV) == DIV - 1) && ((scnt % 10) == 9);
  endfunction

  // one clock: sample inputs, advance the model, return #1 after the edge
  task automatic tick();
    bit slot, acc, ld, ur, en, uc;
    int ph;
    logic [7:0] sd;
    logic [7:0] y[10];
    en = enable; uc = underrun_clr; sd = s_data;
    slot = en && ((ecyc % DIV) == DIV - 1);
    ph   = scnt % 10;
    acc  = s_valid && erdy;
    ld   = slot && (ph == 9);
    ur   = ld && (hq.size() == 0);
    for (int k = 0; k < 10; k++) y[k] = ex0 + 8'(k);
    @(posedge clk); #1;
    ece10 = slot;
    ece   = slot && (ph == 0);
    emv   = slot && ovalid;
    if (slot) emd = eob[ph];
    if (ld) begin
      eob = y;
      if (loads >= 2) ovalid = 1;
      if (loads < 3) loads++;
      ex0 = ex1;
      if (hq.size() > 0) ex1 = hq.pop_front();
    end
    if (acc) hq.push_back(sd);
    if (uc) eur = 0;
    if (ur) eur = 1;
`ifdef INTERP_SEQ_UNDERRUN_CNT_EN
    if (uc) ecnt = ur ? 1 : 0;
    else if (ur && ecnt < 255) ecnt++;
`endif
    erdy = (hq.size() == 0);
    if (en) begin
      ecyc++;
      if (slot) scnt++;
    end else begin
      ecyc = 0; scnt = 0;
    end
  endtask

  task automatic do_reset();
    reset = 1; s_valid = 0; underrun_clr = 0; enable = 1; end_stage = 1;
    model_reset();
    @(negedge clk); reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; enable = 1; s_valid = 0; s_data = 0; underrun_clr = 0; end_stage = 1;
    model_reset();
    #3;
    tot_cnt += 6;
    if (s_ready !== 1'b0) $display("FAIL reset_s_ready got %b want 0", s_ready); else pass_cnt++;
    if ({clk_en, clk_en_10x} !== 2'b00) $display("FAIL reset_strobes got %b want 00", {clk_en, clk_en_10x}); else pass_cnt++;
    if ({x0, x1} !== 16'h0) $display("FAIL reset_x got %h want 0000", {x0, x1}); else pass_cnt++;
    if ({m_data, m_valid} !== 9'h0) $display("FAIL reset_m got %h want 000", {m_data, m_valid}); else pass_cnt++;
    if (underrun !== 1'b0) $display("FAIL reset_underrun got %b want 0", underrun); else pass_cnt++;
    if (underrun_cnt !== 8'h00) $display("FAIL reset_cnt got %h want 00", underrun_cnt); else pass_cnt++;
    @(negedge clk); reset = 0;
    tick();
    tot_cnt++;
    if (s_ready !== 1'b1) $display("FAIL reset_ready_after got %b want 1", s_ready); else pass_cnt++;
  endtask

  task automatic test_cadence();
    do_reset();
    for (int t = 1; t <= 60; t++) begin
      tick();
      tot_cnt += 2;
      if (clk_en_10x !== ((t % DIV) == 0)) $display("FAIL cadence_10x t=%0d got %b want %b", t, clk_en_10x, (t % DIV) == 0); else pass_cnt++;
      if (clk_en !== ((t % (10*DIV)) == DIV)) $display("FAIL cadence_frame t=%0d got %b want %b", t, clk_en, (t % (10*DIV)) == DIV); else pass_cnt++;
    end
  endtask

  task automatic test_stream();
    logic [7:0] vals[3];
    int idx, npulse;
    bit acc;
    vals[0] = 8'h10; vals[1] = 8'h20; vals[2] = 8'h30;
    idx = 0; npulse = 0;
    do_reset();
    for (int t = 1; t <= 80; t++) begin
      s_valid = (idx < 3);
      s_data  = (idx < 3) ? vals[idx] : 8'h00;
      acc = s_valid && erdy;
      tick();
      if (acc) idx++;
      tot_cnt += 2;
      if ({x0, x1} !== {ex0, ex1}) $display("FAIL stream_x t=%0d got %h want %h", t, {x0, x1}, {ex0, ex1}); else pass_cnt++;
      if (m_valid !== emv) $display("FAIL stream_mvalid t=%0d got %b want %b", t, m_valid, emv); else pass_cnt++;
      if (t == 2*10*DIV) begin
        tot_cnt++;
        if ({x0, x1} !== 16'h1020) $display("FAIL stream_pair got %h want 1020", {x0, x1}); else pass_cnt++;
      end
      if (m_valid) begin
        tot_cnt++;
        if (m_data !== 8'h10 + 8'(npulse)) $display("FAIL stream_mdata n=%0d got %h want %h", npulse, m_data, 8'h10 + 8'(npulse)); else pass_cnt++;
        npulse++;
      end
    end
    s_valid = 0;
    tot_cnt++;
    if (npulse !== 10) $display("FAIL stream_pulses got %0d want 10", npulse); else pass_cnt++;
  endtask

  task automatic test_underrun();
    logic [7:0] px1;
    bit ld;
    int bound;
    s_valid = 0;
    for (int t = 0; t < 3*10*DIV; t++) begin
      ld = will_load(); px1 = ex1;
      tick();
      tot_cnt += 2;
      if (underrun !== eur) $display("FAIL underrun_flag got %b want %b", underrun, eur); else pass_cnt++;
      if (underrun_cnt !== 8'(ecnt)) $display("FAIL underrun_cnt got %0d want %0d", underrun_cnt, ecnt); else pass_cnt++;
      if (ld) begin
        tot_cnt++;
        if ({x0, x1, underrun} !== {px1, px1, 1'b1}) $display("FAIL underrun_repeat got %h want %h", {x0, x1, underrun}, {px1, px1, 1'b1}); else pass_cnt++;
      end
    end
    // plain clear away from any load
    underrun_clr = 1; tick(); underrun_clr = 0;
    tot_cnt += 2;
    if (underrun !== 1'b0) $display("FAIL clr_flag got %b want 0", underrun); else pass_cnt++;
    if (underrun_cnt !== 8'h00) $display("FAIL clr_cnt got %h want 00", underrun_cnt); else pass_cnt++;
    bound = 0;
    while (!will_load() && bound < 40) begin tick(); bound++; end
    tot_cnt++;
    if (bound >= 40) $display("FAIL clr_wait got timeout want load"); else pass_cnt++;
    underrun_clr = 1; tick(); underrun_clr = 0;
    tot_cnt += 2;
    if (underrun !== 1'b1) $display("FAIL clr_vs_set got %b want 1", underrun); else pass_cnt++;
`ifdef INTERP_SEQ_UNDERRUN_CNT_EN
    if (underrun_cnt !== 8'h01) $display("FAIL clr_vs_inc got %h want 01", underrun_cnt); else pass_cnt++;
`else
    if (underrun_cnt !== 8'h00) $display("FAIL clr_vs_inc got %h want 00", underrun_cnt); else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid();
    int bound;
    do_reset();
    bound = 0;
    while ((bound < 65 || (scnt % 10) != 5) && bound < 200) begin
      s_valid = ($urandom_range(0, 9) < 7); s_data = 8'($urandom);
      tick(); bound++;
    end
    s_valid = 0;
    #2 reset = 1;
    #1;
    tot_cnt += 3;
    if ({s_ready, clk_en, clk_en_10x, m_valid, underrun} !== 5'b0) $display("FAIL mid_reset_flags got %b want 00000", {s_ready, clk_en, clk_en_10x, m_valid, underrun}); else pass_cnt++;
    if ({x0, x1, m_data} !== 24'h0) $display("FAIL mid_reset_data got %h want 000000", {x0, x1, m_data}); else pass_cnt++;
    if (underrun_cnt !== 8'h00) $display("FAIL mid_reset_cnt got %h want 00", underrun_cnt); else pass_cnt++;
    model_reset();
    @(negedge clk); reset = 0;
    for (int t = 1; t <= 2*10*DIV + 10; t++) begin
      s_valid = 1; s_data = 8'($urandom);
      tick();
      tot_cnt++;
      if (m_valid !== 1'b0) $display("FAIL mid_reset_reprime t=%0d got %b want 0", t, m_valid); else pass_cnt++;
    end
    s_valid = 0;
  endtask

  task automatic test_enable();
    logic [7:0] sx0, sx1;
    int bound;
    bit seen;
    bound = 0;
    while ((scnt % 10) != 4 && bound < 40) begin tick(); bound++; end
    sx0 = ex0; sx1 = ex1;
    enable = 0;
    for (int t = 0; t < 7; t++) begin
      tick();
      tot_cnt++;
      if ({clk_en_10x, m_valid, x0, x1} !== {1'b0, 1'b0, sx0, sx1}) $display("FAIL enable_low got %h want %h", {clk_en_10x, m_valid, x0, x1}, {1'b0, 1'b0, sx0, sx1}); else pass_cnt++;
    end
    enable = 1;
    seen = 0;
    for (int t = 0; t < 4*DIV && !seen; t++) begin
      tick();
      if (clk_en_10x) seen = 1;
    end
    tot_cnt += 2;
    if (!seen) $display("FAIL enable_rise got no slot want slot");
    else if (clk_en !== 1'b1) $display("FAIL enable_rise got clk_en=%b want 1", clk_en);
    else pass_cnt++;
    if ({x0, x1} !== {sx0, sx1}) $display("FAIL enable_pair got %h want %h", {x0, x1}, {sx0, sx1}); else pass_cnt++;
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 800; t++) begin
      s_valid      = $urandom_range(0, 9) < 6;
      s_data       = 8'($urandom);
      underrun_clr = $urandom_range(0, 19) == 0;
      enable       = $urandom_range(0, 49) != 0;
      end_stage    = $urandom_range(0, 1) == 1;
      tick();
      tot_cnt += 5;
      if ({s_ready, clk_en, clk_en_10x} !== {erdy, ece, ece10}) $display("FAIL rand_ctl t=%0d got %b want %b", t, {s_ready, clk_en, clk_en_10x}, {erdy, ece, ece10}); else pass_cnt++;
      if ({x0, x1} !== {ex0, ex1}) $display("FAIL rand_x t=%0d got %h want %h", t, {x0, x1}, {ex0, ex1}); else pass_cnt++;
      if ({m_valid, m_data} !== {emv, emd}) $display("FAIL rand_m t=%0d got %h want %h", t, {m_valid, m_data}, {emv, emd}); else pass_cnt++;
      if (underrun !== eur) $display("FAIL rand_ur t=%0d got %b want %b", t, underrun, eur); else pass_cnt++;
      if (underrun_cnt !== 8'(ecnt)) $display("FAIL rand_cnt t=%0d got %0d want %0d", t, underrun_cnt, ecnt); else pass_cnt++;
    end
    enable = 1; underrun_clr = 0; s_valid = 0; end_stage = 1;
  endtask

  initial begin
    test_reset();
    test_cadence();
    test_stream();
    test_underrun();
    test_reset_mid();
    test_enable();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
